// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 / stride-2 pooling (signed max or floor average) over raster pixels.
// Latency: pooled pixel is valid the cycle after the accepting edge of the window's bottom-right beat.
// Backpressure: single output register, no skid; in_ready = !out_valid || out_ready stalls every beat.
module maxpool_stream #(
  parameter int BITWIDTH = 16,
  parameter int CHANNELS = 2,
  parameter int IN_W     = 28,
  parameter int IN_H     = 28,
  parameter int MODE     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data,
  output logic                         frame_done
);

  localparam int DW    = CHANNELS * BITWIDTH;
  localparam int AW    = BITWIDTH + 2;
  localparam int LW    = (MODE == 1) ? AW : BITWIDTH;
  localparam int LBW   = CHANNELS * LW;
  localparam int LB_N  = (IN_W >= 2) ? IN_W / 2 : 1;
  localparam int COL_W = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam int ROW_W = (IN_H > 2) ? $clog2(IN_H) : 1;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  // Geometry and mode sanity: odd dimensions would leave half-windows at the map edge.
  if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_in_w
    $error("maxpool_stream: IN_W must be even and at least 2");
  end
  if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_in_h
    $error("maxpool_stream: IN_H must be even and at least 2");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("maxpool_stream: MODE must be 0 (max) or 1 (average)");
  end

  // Frame position and the even-column sample waiting for its right-hand neighbour.
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [DW-1:0]    hold_q, hold_d;

  // Output stage; out_last_q marks the bottom-right pooled pixel of the frame.
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  // Half-row line buffer: one horizontally combined pair per output column.
  logic [LBW-1:0]   lb_q [LB_N];
  logic [LB_AW-1:0] lb_idx;
  logic [LBW-1:0]   lb_rd;

  // Combine results for the current beat.
  logic [LBW-1:0]   pair_val;
  logic [DW-1:0]    quad_val;

  logic accept;
  logic col_odd;
  logic row_odd;
  logic last_col;
  logic last_row;
  logic load;
  logic lb_we;
  logic drain;

  // Handshake and position decode; clear wins over a simultaneous beat, which is dropped.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready && !clear;
    col_odd  = col_q[0];
    row_odd  = row_q[0];
    last_col = (col_q == COL_W'(IN_W - 1));
    last_row = (row_q == ROW_W'(IN_H - 1));
    load     = accept && col_odd && row_odd;
    lb_we    = accept && col_odd && !row_odd;
    drain    = out_valid_q && out_ready;
    lb_idx   = LB_AW'(col_q >> 1);
    lb_rd    = lb_q[lb_idx];
  end

  if (MODE == 1) begin : g_avg
    function automatic logic signed [AW-1:0] sx(input logic signed [BITWIDTH-1:0] v);
      return AW'(v);
    endfunction

    logic signed [AW-1:0] quad_sum;

    // Average: pair sum kept at full width in the line buffer; four-sample sum shifted right by 2
    // (floor). The 4-sample sum always fits in BITWIDTH+2 bits, so the truncated result cannot wrap.
    always_comb begin
      pair_val = '0;
      quad_val = '0;
      quad_sum = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        pair_val[c*AW +: AW] = sx(hold_q[c*BITWIDTH +: BITWIDTH]) + sx(in_data[c*BITWIDTH +: BITWIDTH]);
        quad_sum = sx(hold_q[c*BITWIDTH +: BITWIDTH]) + sx(in_data[c*BITWIDTH +: BITWIDTH])
                   + $signed(lb_rd[c*AW +: AW]);
        quad_val[c*BITWIDTH +: BITWIDTH] = quad_sum[AW-1:2];
      end
    end
  end else begin : g_max
    function automatic logic signed [BITWIDTH-1:0] smax(input logic signed [BITWIDTH-1:0] a,
                                                        input logic signed [BITWIDTH-1:0] b);
      return (a > b) ? a : b;
    endfunction

    logic signed [BITWIDTH-1:0] pair_max;

    // Max: horizontal pair max goes to the line buffer; the odd row folds in the stored pair.
    always_comb begin
      pair_val = '0;
      quad_val = '0;
      pair_max = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        pair_max = smax(hold_q[c*BITWIDTH +: BITWIDTH], in_data[c*BITWIDTH +: BITWIDTH]);
        pair_val[c*BITWIDTH +: BITWIDTH] = pair_max;
        quad_val[c*BITWIDTH +: BITWIDTH] = smax(pair_max, lb_rd[c*BITWIDTH +: BITWIDTH]);
      end
    end
  end

  // Raster counters advance only on accepted beats; even columns park the beat in the hold register.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      hold_d = '0;
    end else if (accept) begin
      if (!col_odd) begin
        hold_d = in_data;
      end
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Output register: a new result wins over a same-cycle drain; clear discards any pending result.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = quad_val;
      out_last_d  = last_row && last_col;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Frame-done is tied to the downstream handshake of the final pooled pixel, never to a discarded one.
  always_comb begin
    out_valid  = out_valid_q;
    out_data   = out_data_q;
    frame_done = drain && out_last_q && !clear;
  end

  // State registers; reset mid-frame behaves like clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer storage; contents are don't-care after reset or clear since row 0 rewrites them.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= pair_val;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: scoreboard bench for two pooling instances (max 4x4 and average 28x28).
// Latency: expected windows are queued at stimulus time and popped by a monitor on each handshake.
// Backpressure: out_ready per instance is always-on, random or held low under bench control.
module tb_maxpool_stream;

  typedef struct {
    int c0;
    int c1;
    bit last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clear     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic        frame_done[2];

  int   n_checks;
  int   n_fail;
  int   rdy_mode[2];
  int   done_cnt[2];
  int   out_cnt [2];
  int   pix0[2][784];
  int   pix1[2][784];
  exp_t expq0[$];
  exp_t expq1[$];
  exp_t e;
  int   tmo;
  int   snap_done;
  int   snap_out;

  maxpool_stream #(.BITWIDTH(16), .CHANNELS(2), .IN_W(4), .IN_H(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .frame_done(frame_done[0]));

  maxpool_stream #(.BITWIDTH(16), .CHANNELS(2), .IN_W(28), .IN_H(28), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .frame_done(frame_done[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got stuck, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int geom(input int i);
    return (i == 0) ? 4 : 28;
  endfunction

  // Reference: max or floor-average of each 2x2 window, written directly from the pooling rule.
  function automatic int pool4(input int mode, input int a, input int b, input int c, input int d);
    int m;
    int s;
    if (mode == 0) begin
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
    end
    s = a + b + c + d;
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  task automatic model(input int i);
    exp_t r;
    int   w;
    w = geom(i);
    for (int y = 0; y < w; y += 2) begin
      for (int x = 0; x < w; x += 2) begin
        r.c0 = pool4(i, pix0[i][y*w+x], pix0[i][y*w+x+1], pix0[i][(y+1)*w+x], pix0[i][(y+1)*w+x+1]);
        r.c1 = pool4(i, pix1[i][y*w+x], pix1[i][y*w+x+1], pix1[i][(y+1)*w+x], pix1[i][(y+1)*w+x+1]);
        r.last = (y == w - 2) && (x == w - 2);
        if (i == 0) expq0.push_back(r);
        else        expq1.push_back(r);
      end
    end
  endtask

  function automatic int rand16();
    logic signed [15:0] t;
    if ($urandom_range(0, 3) == 0) t = 16'($urandom_range(0, 3)) - 16'sd2;
    else                           t = 16'($urandom);
    return int'(t);
  endfunction

  task automatic fill_rand(input int i);
    for (int k = 0; k < geom(i) * geom(i); k++) begin
      pix0[i][k] = rand16();
      pix1[i][k] = rand16();
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 16; k++) begin
      pix0[0][k] = k;
      pix1[0][k] = -k;
    end
  endtask

  // Drive n beats of the current frame; optionally queue the whole frame's expected outputs first.
  task automatic send(input int i, input int n, input bit push, input bit gaps);
    int          t;
    bit          acc;
    int          w;
    logic [15:0] d0;
    logic [15:0] d1;
    w = geom(i);
    if (push) model(i);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid[i] = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      d0 = 16'(pix0[i][k]);
      d1 = 16'(pix1[i][k]);
      in_valid[i] = 1'b1;
      in_data[i]  = {d1, d0};
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = in_ready[i];
        @(posedge clk);
        #1;
        t++;
      end
      check($sformatf("accept inst%0d beat%0d", i, k), acc, 1);
      if (((k / w) % 2 == 1) && ((k % w) % 2 == 1))
        check($sformatf("latency inst%0d beat%0d", i, k), out_valid[i], 1);
    end
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_empty(input int i);
    int t;
    t = 0;
    while (((i == 0) ? expq0.size() : expq1.size()) != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check($sformatf("drained inst%0d", i), (i == 0) ? expq0.size() : expq1.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      case (rdy_mode[i])
        0:       out_ready[i] = 1'b1;
        1:       out_ready[i] = ($urandom_range(0, 3) != 0);
        default: out_ready[i] = 1'b0;
      endcase
    end
  end

  // Monitor: a handshake visible at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && frame_done[i]) done_cnt[i]++;
      if (rst_n && out_valid[i] && out_ready[i] && !clear[i]) begin
        check($sformatf("expected output pending inst%0d", i),
              ((i == 0) ? expq0.size() : expq1.size()) > 0, 1);
        if (((i == 0) ? expq0.size() : expq1.size()) > 0) begin
          if (i == 0) e = expq0.pop_front();
          else        e = expq1.pop_front();
          out_cnt[i]++;
          check($sformatf("out_data inst%0d #%0d", i, out_cnt[i]), out_data[i], {e.c1[15:0], e.c0[15:0]});
          check($sformatf("frame_done inst%0d #%0d", i, out_cnt[i]), frame_done[i], e.last);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clear[i]    = 1'b0;
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      rdy_mode[i] = 0;
      done_cnt[i] = 0;
      out_cnt[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset out_valid inst%0d", i), out_valid[i], 0);
      check($sformatf("reset out_data inst%0d", i), out_data[i], 0);
      check($sformatf("reset frame_done inst%0d", i), frame_done[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle in_ready", in_ready[0], 1);

    // Ramp frame, always ready: 5,7,13,15 on ch0 and 0,-2,-8,-10 on ch1.
    fill_ramp();
    send(0, 16, 1, 0);
    wait_empty(0);
    check("ramp frame_done count", done_cnt[0], 1);

    // Hold out_ready low behind the first output, then release.
    fill_ramp();
    rdy_mode[0] = 2;
    fork
      send(0, 16, 1, 0);
      begin
        tmo = 0;
        while (!out_valid[0] && tmo < 100) begin
          @(negedge clk);
          tmo++;
        end
        check("bp first output seen", out_valid[0], 1);
        repeat (4) begin
          @(negedge clk);
          check("bp in_ready low", in_ready[0], 0);
          check("bp out_data held", out_data[0], 32'h0000_0005);
        end
        rdy_mode[0] = 0;
      end
    join
    wait_empty(0);
    check("bp frame_done count", done_cnt[0], 2);

    // Random frames, random ready and input gaps.
    rdy_mode[0] = 1;
    for (int f = 0; f < 3; f++) begin
      fill_rand(0);
      send(0, 16, 1, 1);
    end
    wait_empty(0);
    check("random frame_done count", done_cnt[0], 5);

    // Abort a frame after 6 beats with an output pending, then a fresh frame.
    fill_rand(0);
    rdy_mode[0] = 2;
    send(0, 6, 0, 0);
    check("pending before clear", out_valid[0], 1);
    clear[0] = 1'b1;
    @(posedge clk);
    #1;
    clear[0] = 1'b0;
    check("clear out_valid", out_valid[0], 0);
    check("clear in_ready", in_ready[0], 1);
    snap_out = out_cnt[0];
    rdy_mode[0] = 1;
    fill_rand(0);
    send(0, 16, 1, 1);
    wait_empty(0);
    check("clear output count", out_cnt[0] - snap_out, 4);
    check("clear frame_done count", done_cnt[0], 6);

    // Average mode: negative floor, saturated positive and negative windows, random elsewhere.
    fill_rand(1);
    pix0[1][0]  = -1;     pix0[1][1]  = -2;     pix0[1][28] = -3;     pix0[1][29] = -4;
    pix0[1][2]  = 32767;  pix0[1][3]  = 32767;  pix0[1][30] = 32767;  pix0[1][31] = 32767;
    pix0[1][4]  = -32768; pix0[1][5]  = -32768; pix0[1][32] = -32768; pix0[1][33] = -32768;
    rdy_mode[1] = 1;
    send(1, 784, 1, 1);
    wait_empty(1);
    check("avg frame_done count", done_cnt[1], 1);

    // Asynchronous reset between edges with an output pending, then a full frame.
    rdy_mode[1] = 2;
    fill_rand(1);
    send(1, 30, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid[1], 0);
    check("async rst out_data", out_data[1], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap_out  = out_cnt[1];
    snap_done = done_cnt[1];
    rdy_mode[1] = 1;
    fill_rand(1);
    send(1, 784, 1, 1);
    wait_empty(1);
    check("post-reset output count", out_cnt[1] - snap_out, 196);
    check("post-reset frame_done count", done_cnt[1] - snap_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
